// File: rtl/regwb_pkg.sv
// Shared definitions for the register-file writeback arbiter:
// register index width, default data width, writeback source IDs,
// the per-source buffer state type and a small rd helper.
package regwb_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int XLEN_DEFAULT = 32;

    // Writeback source IDs (position in the req_* vectors)
    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MUL = 2;

    // One-entry input buffer state
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Writes to x0 are architecturally discarded
    function automatic logic rd_is_zero(input logic [REG_ADDR_W-1:0] rd);
        return (rd == {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request found when
// scanning upward from ptr (wrapping at N) wins. Outputs a one-hot grant,
// the winner's index and an any-request flag. ptr must be below N.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    // Scan N positions starting at ptr and grant the first requester found
    always_comb begin
        int pos_s;
        gnt     = {N{1'b0}};
        gnt_idx = {IDX_W{1'b0}};
        any     = 1'b0;
        pos_s   = 0;
        for (int k = 0; k < N; k++) begin
            pos_s = int'(ptr) + k;
            if (pos_s >= N) begin
                pos_s = pos_s - N;
            end else begin
                pos_s = pos_s;
            end
            if (!any && req[pos_s]) begin
                gnt[pos_s] = 1'b1;
                gnt_idx    = IDX_W'(pos_s);
                any        = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter. N_REQ writeback sources each own a
// one-entry buffer with a valid/ready handshake; a round-robin arbiter
// grants one full buffer per cycle into a registered write port.
// Writes to x0 are accepted, then dropped at grant time (slot still used).
// Optional feature macro: REGWB_SCOREBOARD_EN adds issue_valid/issue_rd
// inputs and a busy_mask output tracking outstanding register writes.
module regfile_wb_arbiter
    import regwb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
`ifdef REGWB_SCOREBOARD_EN
    input  logic                        issue_valid,
    input  logic [REG_ADDR_W-1:0]       issue_rd,
    output logic [31:0]                 busy_mask,
`endif
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [REG_ADDR_W*N_REQ-1:0] req_rd,
    input  logic [XLEN*N_REQ-1:0]       req_data,
    output logic                        wb_en,
    output logic [REG_ADDR_W-1:0]       wb_rd,
    output logic [XLEN-1:0]             wb_data,
    output logic [$clog2(N_REQ)-1:0]    wb_src
);

    localparam int SRC_W = $clog2(N_REQ);

    buf_state_e              buf_state_r [N_REQ];
    buf_state_e              buf_state_s [N_REQ];
    logic [N_REQ-1:0]        ready_r;
    logic [N_REQ-1:0]        full_s;
    logic [N_REQ-1:0]        accept_s;
    logic [N_REQ-1:0]        gnt_s;
    logic [REG_ADDR_W-1:0]   buf_rd_r   [N_REQ];
    logic [XLEN-1:0]         buf_data_r [N_REQ];

    logic [SRC_W-1:0]        ptr_r;
    logic [SRC_W-1:0]        ptr_next_s;
    logic [SRC_W-1:0]        gnt_idx_s;
    logic                    any_s;

    logic [REG_ADDR_W-1:0]   sel_rd_s;
    logic [XLEN-1:0]         sel_data_s;
    logic                    write_s;

    logic                    wb_en_r;
    logic [REG_ADDR_W-1:0]   wb_rd_r;
    logic [XLEN-1:0]         wb_data_r;
    logic [SRC_W-1:0]        wb_src_r;

    // Buffer occupancy and handshake completion per source
    always_comb begin
        full_s   = {N_REQ{1'b0}};
        accept_s = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            full_s[i]   = (buf_state_r[i] == BUF_FULL);
            accept_s[i] = req_valid[i] & ready_r[i];
        end
    end

    // Buffer FSM next state: fill on handshake, drain on grant
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            buf_state_s[i] = buf_state_r[i];
            case (buf_state_r[i])
                BUF_EMPTY: begin
                    if (accept_s[i]) begin
                        buf_state_s[i] = BUF_FULL;
                    end else begin
                        buf_state_s[i] = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (gnt_s[i]) begin
                        buf_state_s[i] = BUF_EMPTY;
                    end else begin
                        buf_state_s[i] = BUF_FULL;
                    end
                end
                default: buf_state_s[i] = BUF_EMPTY;
            endcase
        end
    end

    // Buffer state register; ready is registered from the next state so it
    // never depends combinationally on req_valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                buf_state_r[i] <= BUF_EMPTY;
            end
            ready_r <= {N_REQ{1'b1}};
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                buf_state_r[i] <= buf_state_s[i];
                ready_r[i]     <= (buf_state_s[i] == BUF_EMPTY);
            end
        end
    end

    // Buffer payload capture on handshake
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                buf_rd_r[i]   <= {REG_ADDR_W{1'b0}};
                buf_data_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept_s[i]) begin
                    buf_rd_r[i]   <= req_rd[REG_ADDR_W*i +: REG_ADDR_W];
                    buf_data_r[i] <= req_data[XLEN*i +: XLEN];
                end
            end
        end
    end

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (SRC_W)
    ) u_rr_arbiter (
        .req     (full_s),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    // One-hot AND-OR select of the granted buffer's payload
    always_comb begin
        sel_rd_s   = {REG_ADDR_W{1'b0}};
        sel_data_s = {XLEN{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            sel_rd_s   = sel_rd_s   | (buf_rd_r[i]   & {REG_ADDR_W{gnt_s[i]}});
            sel_data_s = sel_data_s | (buf_data_r[i] & {XLEN{gnt_s[i]}});
        end
        write_s = any_s & ~rd_is_zero(sel_rd_s);
    end

    // Pointer moves past the winner, including dropped x0 requests
    always_comb begin
        if (any_s) begin
            if (gnt_idx_s == SRC_W'(N_REQ - 1)) begin
                ptr_next_s = {SRC_W{1'b0}};
            end else begin
                ptr_next_s = gnt_idx_s + {{(SRC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_r <= {SRC_W{1'b0}};
        end else begin
            ptr_r <= ptr_next_s;
        end
    end

    // Registered write port; rd/data/src hold while no write is issued
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_en_r   <= 1'b0;
            wb_rd_r   <= {REG_ADDR_W{1'b0}};
            wb_data_r <= {XLEN{1'b0}};
            wb_src_r  <= {SRC_W{1'b0}};
        end else begin
            wb_en_r <= write_s;
            if (write_s) begin
                wb_rd_r   <= sel_rd_s;
                wb_data_r <= sel_data_s;
                wb_src_r  <= gnt_idx_s;
            end
        end
    end

    assign req_ready = ready_r;
    assign wb_en     = wb_en_r;
    assign wb_rd     = wb_rd_r;
    assign wb_data   = wb_data_r;
    assign wb_src    = wb_src_r;

`ifdef REGWB_SCOREBOARD_EN
    logic [31:0] busy_r;
    logic [31:0] busy_s;
    logic        drop_s;

    // Busy-mask update: clears first, then issue sets so set wins; x0 never busy
    always_comb begin
        drop_s = any_s & rd_is_zero(sel_rd_s);
        busy_s = busy_r;
        if (wb_en_r) begin
            busy_s[wb_rd_r] = 1'b0;
        end else begin
            busy_s = busy_s;
        end
        if (drop_s) begin
            busy_s[sel_rd_s] = 1'b0;
        end else begin
            busy_s = busy_s;
        end
        if (issue_valid) begin
            busy_s[issue_rd] = 1'b1;
        end else begin
            busy_s = busy_s;
        end
        busy_s[0] = 1'b0;
    end

    // Busy-mask register
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_s;
        end
    end

    assign busy_mask = busy_r;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter (default build, REGWB_SCOREBOARD_EN undefined).
// A reference model queues expected writes; a negedge monitor compares them.
module tb_regfile_wb_arbiter;
    import regwb_pkg::*;

    localparam int N  = 3;
    localparam int XL = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [5*N-1:0]  req_rd;
    logic [XL*N-1:0] req_data;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XL-1:0]   wb_data;
    logic [1:0]      wb_src;

    regfile_wb_arbiter #(.N_REQ(N), .XLEN(XL)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_src    (wb_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
        int          src;
    } exp_t;

    exp_t        expQ[$];
    int          edgeCnt     = 0;
    int          nCompared   = 0;
    int          nMismatched = 0;

    bit          mFull [N];
    logic [4:0]  mRd   [N];
    logic [31:0] mData [N];
    int          mPtr     = 0;
    logic [4:0]  lastRd   = 5'd0;
    logic [31:0] lastData = 32'd0;
    int          lastSrc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edgeCnt);
        end
    endtask

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Reference model: each buffer holds at most one write; every cycle the
    // first full buffer at or after the pointer leaves, and its write (unless
    // to x0) is expected on the port right after this edge.
    always @(posedge clk) begin : model
        int   w;
        int   s;
        bit   acc [N];
        exp_t e;
        if (!reset) begin
            for (int i = 0; i < N; i++) mFull[i] = 1'b0;
            mPtr     = 0;
            lastRd   = 5'd0;
            lastData = 32'd0;
            lastSrc  = 0;
        end else begin
            for (int i = 0; i < N; i++) acc[i] = !mFull[i] && req_valid[i];
            w = -1;
            for (int k = 0; k < N; k++) begin
                s = (mPtr + k) % N;
                if (w < 0 && mFull[s]) w = s;
            end
            if (w >= 0) begin
                if (mRd[w] != 5'd0) begin
                    e.due  = edgeCnt + 1;
                    e.rd   = mRd[w];
                    e.data = mData[w];
                    e.src  = w;
                    expQ.push_back(e);
                end
                mFull[w] = 1'b0;
                mPtr     = (w + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    mFull[i] = 1'b1;
                    mRd[i]   = req_rd[5*i +: 5];
                    mData[i] = req_data[XL*i +: XL];
                end
            end
        end
    end

    // Monitor: compares port state against the model mid-cycle
    always @(negedge clk) begin : monitor
        bit         expEn;
        logic [N-1:0] er;
        exp_t       e;
        if (edgeCnt >= 1) begin
            for (int i = 0; i < N; i++) er[i] = !mFull[i];
            check("req_ready", 32'(req_ready), 32'(er));
            while (expQ.size() > 0 && expQ[0].due < edgeCnt) begin
                check("missing_write_due_edge", 32'(edgeCnt), 32'(expQ[0].due));
                void'(expQ.pop_front());
            end
            expEn = (expQ.size() > 0) && (expQ[0].due == edgeCnt);
            check("wb_en", 32'(wb_en), 32'(expEn));
            if (wb_en && expEn) begin
                e = expQ.pop_front();
                check("wb_rd", 32'(wb_rd), 32'(e.rd));
                check("wb_data", wb_data, e.data);
                check("wb_src", 32'(wb_src), 32'(e.src));
                lastRd   = e.rd;
                lastData = e.data;
                lastSrc  = e.src;
            end else if (!wb_en) begin
                check("wb_rd_hold", 32'(wb_rd), 32'(lastRd));
                check("wb_data_hold", wb_data, lastData);
                check("wb_src_hold", 32'(wb_src), 32'(lastSrc));
            end
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic [5*N-1:0] rds, input logic [XL*N-1:0] ds);
        req_valid = v;
        req_rd    = rds;
        req_data  = ds;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single ALU write
        drive(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEADBEEF});
        idle(4);
        // MUL write brings the pointer back to 0
        drive(3'b100, {5'd4, 5'd0, 5'd0}, {32'h44444444, 32'd0, 32'd0});
        idle(3);
        // All three full at once
        drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33333333, 32'h22222222, 32'h11111111});
        idle(5);
        // ALU and LSU both keep requesting
        for (int c = 0; c < 12; c++) begin
            drive(3'b011, {5'd0, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))},
                  {32'd0, 32'($urandom), 32'($urandom)});
        end
        idle(4);
        // Write to x0 followed by a real write
        drive(3'b011, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hCAFE0007, 32'h00001234});
        idle(4);
        // Reset while two buffers are full
        drive(3'b011, {5'd0, 5'd10, 5'd11}, {32'd0, 32'hA0A0A0A0, 32'hB1B1B1B1});
        req_valid = '0;
        reset     = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(4);

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) != 0);
            drive(3'($urandom_range(0, 7)), 15'($urandom),
                  {32'($urandom), 32'($urandom), 32'($urandom)});
        end
        reset = 1'b1;
        idle(8);

        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
